// File: rtl/stream_byte_packer.sv
// ---------------------------------------------------------------------------
// stream_byte_packer
//
// Gathers a serial byte stream into beats of REPLICATION_FACTOR bytes and
// presents them on a wide valid/ready/last interface. A packet that ends
// mid-beat is flushed as a partial beat with unfilled lanes set to PAD_BYTE.
//
// Parameters:
//   REPLICATION_FACTOR  bytes per output beat (2 or more)
//   PAD_BYTE            fill value for the unused lanes of a partial last beat
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high; clears all state and drops any
//              partial word
//   enable     when low no input bytes are accepted; output still drains
//   in_data    input byte
//   in_valid   in_data is valid
//   in_ready   packer accepts a byte this cycle
//   in_last    this byte ends the packet
//   out_data   packed beat, lane k in bits [8k+7:8k], first byte in lane 0
//   out_valid  beat held and valid
//   out_ready  downstream accepts the beat
//   out_last   beat ends the packet
//   out_count  (only with PACKER_BYTE_COUNT_EN) number of real bytes in beat
//
// Optional feature macro: PACKER_BYTE_COUNT_EN
// ---------------------------------------------------------------------------
module stream_byte_packer #(
    parameter int         REPLICATION_FACTOR = 3,
    parameter logic [7:0] PAD_BYTE           = 8'h00
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    output logic [8*REPLICATION_FACTOR-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last
`ifdef PACKER_BYTE_COUNT_EN
    ,
    output logic [$clog2(REPLICATION_FACTOR+1)-1:0] out_count
`endif
);

    localparam int R  = REPLICATION_FACTOR;
    localparam int IW = $clog2(R);
    localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);
`ifdef PACKER_BYTE_COUNT_EN
    localparam int CW = $clog2(R + 1);
`endif

    // Accumulator holds only R-1 lanes: the byte that fills the final lane
    // goes straight into the holding register together with the others.
    logic [R-2:0][7:0] acc_q, acc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [8*R-1:0]    out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
`ifdef PACKER_BYTE_COUNT_EN
    logic [CW-1:0]     out_count_q, out_count_d;
`endif

    logic              accept;
    logic              drain;
    logic              complete;
    logic [R-1:0][7:0] beat;

    // Readiness depends only on registered state and the downstream ready,
    // so a held beat that is draining this cycle frees room for a new byte.
    assign in_ready = enable & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;
    assign complete = accept & ((idx_q == LAST_IDX) | in_last);

    // Assemble the outgoing beat: stored lanes below idx, the incoming byte
    // at idx, padding above it.
    always_comb begin
        beat = {R{PAD_BYTE}};
        for (int k = 0; k < R - 1; k++) begin
            if (IW'(k) < idx_q) begin
                beat[k] = acc_q[k];
            end
        end
        for (int k = 0; k < R; k++) begin
            if (IW'(k) == idx_q) begin
                beat[k] = in_data;
            end
        end
    end

    // Next-state logic for the accumulator and the holding register. A
    // completing byte in the same cycle as a drain simply overwrites the
    // drained beat, keeping out_valid high without a bubble.
    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef PACKER_BYTE_COUNT_EN
        out_count_d = out_count_q;
`endif

        if (drain) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            out_data_d  = beat;
            out_valid_d = 1'b1;
            out_last_d  = in_last;
`ifdef PACKER_BYTE_COUNT_EN
            out_count_d = CW'(idx_q) + CW'(1);
`endif
            acc_d       = {(R-1){PAD_BYTE}};
            idx_d       = '0;
        end else if (accept) begin
            for (int k = 0; k < R - 1; k++) begin
                if (IW'(k) == idx_q) begin
                    acc_d[k] = in_data;
                end
            end
            idx_d = idx_q + IW'(1);
        end
    end

    // State registers; reset discards any partially gathered word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= {(R-1){PAD_BYTE}};
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef PACKER_BYTE_COUNT_EN
            out_count_q <= '0;
`endif
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef PACKER_BYTE_COUNT_EN
            out_count_q <= out_count_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
`ifdef PACKER_BYTE_COUNT_EN
    assign out_count = out_count_q;
`endif

endmodule

// File: doc/stream_byte_packer.md
Name: stream_byte_packer

Overview:
- Upstream companion of the replicated-byte stateful processor.
- Gathers a serial byte stream, e.g. from the UART receive path, into beats of REPLICATION_FACTOR bytes.
- Presents each beat on the wide valid/ready/last interface that the processor consumes.
- Pads the final partial beat of a packet and marks it with last.

Parameters:
- REPLICATION_FACTOR, 3: bytes per output beat; legal values are 2 or more.
- PAD_BYTE, 8'h00: value written into unfilled lanes of a partial last beat.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  when low, no input bytes are accepted; output draining continues.
- in_data  input  8  input byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  packer accepts the byte this cycle.
- in_last  input  1  this byte ends the packet.
- out_data  output  8*REPLICATION_FACTOR  packed beat; first byte in bits [7:0], lane k in bits [8k+7:8k].
- out_valid  output  1  beat held and valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  beat ends the packet.

Behaviour:
- Reset values, asynchronous: out_valid=0, out_last=0, out_data=0, lane index=0, accumulator lanes=PAD_BYTE. Any partial word is discarded.
- Handshake:
  - in_ready = enable AND (NOT out_valid OR out_ready). It is registered-state based and never depends on in_valid or in_last.
  - A byte is accepted on a cycle with in_valid AND in_ready.
  - A beat transfers on a cycle with out_valid AND out_ready.
- Storage:
  - Accumulator of REPLICATION_FACTOR-1 byte lanes plus a lane index idx in 0..R-1.
  - One output holding register (out_data/out_last/out_valid).
- Two states:
  - FILL: idx < R-1, the word is not yet complete.
  - COMPLETE event: the byte is accepted with idx==R-1 OR in_last==1.
- Accept without completion:
  - The byte is written to lane idx and idx increments.
  - out_* are unchanged unless the current beat drains, in which case out_valid falls.
- Accept with completion:
  - The holding register loads the accumulator lanes 0..idx-1, the incoming byte in lane idx, and PAD_BYTE in lanes idx+1..R-1.
  - out_last = in_last and out_valid = 1.
  - The accumulator resets to PAD_BYTE and idx = 0.
- Simultaneous drain and completion in one cycle: the new beat replaces the drained one; out_valid stays 1 with no bubble.
- Latency: the byte completing a word at edge N makes the beat visible right after edge N, i.e. one cycle.
- Throughput: one byte per clock while the downstream keeps up.
- Backpressure:
  - While out_valid=1 and out_ready=0, in_ready=0 and no bytes are accepted.
  - The accumulator holds its partial contents.
- out_data/out_last are stable whenever out_valid=1 and out_ready=0.
- in_last with idx==R-1 produces a full beat with last=1 and no padding.
- No empty beats are ever emitted.
- enable falling mid-word:
  - The partial word is retained and acceptance pauses.
  - The pending output beat may still drain.
- idx never exceeds R-1. Wrap to 0 happens only through completion.

Optional Feature:
- Macro PACKER_BYTE_COUNT_EN.
- When defined:
  - Adds output port out_count, width $clog2(REPLICATION_FACTOR+1), registered with out_data.
  - Value is the number of real (non-pad) bytes in the beat: R for full beats, idx+1 for a partial last beat.
  - Reset value 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- R=3, PAD=00: bytes 41,42,43, last on 43, out_ready=1 -> one beat out_data=0x434241, out_last=1, visible one cycle after the 43 handshake (count=3).
- R=3: bytes 01..05, last on 05 -> beats 0x030201 (last=0) then 0x000504 (last=1, count=2).
- R=3: single byte 7F with last -> beat 0x00007F, last=1, count=1. With PAD_BYTE=FF -> 0xFFFF7F.
- Backpressure: out_ready=0 while feeding 01..06 continuously ->
  - First beat 0x030201 is held stable.
  - in_ready=0 from the next cycle until out_ready=1.
  - Then 0x060504 follows; no loss or duplication.
- Reset pulse, asynchronous and mid-cycle, after bytes AA,BB accepted ->
  - out_valid=0 immediately.
  - Next bytes 11,22,33 give 0x332211; AA/BB never appear.
- enable=0 after bytes 10,20 for 5 cycles ->
  - in_ready=0 throughout.
  - On re-enable, byte 30 gives 0x302010.
